// File: rtl/fetch_if.sv
// fetch_if: fetch stage handshake bundle (redirect/stall control, imem bus, IF/ID outputs).
interface fetch_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             redirect_valid;
   logic [31:0]      redirect_target;
   logic [31:0]      imem_pc;
   logic [31:0]      imem_data;
   logic [31:0]      if_pc;
   logic [31:0]      if_instr;
   logic             if_valid;
   logic [CNT_W-1:0] fetch_count;
   modport master (
      input  stall, redirect_valid, redirect_target, imem_data,
      output imem_pc, if_pc, if_instr, if_valid, fetch_count
   );
   modport slave (
      output stall, redirect_valid, redirect_target, imem_data,
      input  imem_pc, if_pc, if_instr, if_valid, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with stall, redirect-flush and saturating fetch counter.
// Define FETCH_WRAP_EN to keep the PC within IMEM_DEPTH (power of 2) words.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 256,
   parameter int          CNT_W      = 16
) (
   input logic     clk,
   input logic     rst_n,
   fetch_if.master bus
);
   logic [31:0]      pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
   logic [31:0]      pc_inc, target;
   logic             if_valid_q, if_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold;

   if (IMEM_DEPTH < 1 || (IMEM_DEPTH & (IMEM_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("IMEM_DEPTH must be a power of 2");
   end

`ifdef FETCH_WRAP_EN
   localparam logic [31:0] LAST = 32'(IMEM_DEPTH - 1);
   assign pc_inc = (pc_q == LAST) ? 32'h0 : pc_q + 32'h1;
   assign target = bus.redirect_target & LAST;
`else
   assign pc_inc = pc_q + 32'h1;
   assign target = bus.redirect_target;
`endif

   // redirect outranks stall; both freeze if_pc and the counter
   assign hold = bus.redirect_valid | bus.stall;

   always_comb begin
      pc_d       = bus.redirect_valid ? target : bus.stall ? pc_q : pc_inc;
      if_instr_d = bus.redirect_valid ? NOP_INSTR : bus.stall ? if_instr_q : bus.imem_data;
      if_valid_d = bus.redirect_valid ? 1'b0 : bus.stall ? if_valid_q : 1'b1;
      if_pc_d    = hold ? if_pc_q : pc_q;
      cnt_d      = (hold || &cnt_q) ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         if_pc_q    <= 32'h0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.imem_pc     = pc_q;
   assign bus.if_pc       = if_pc_q;
   assign bus.if_instr    = if_instr_q;
   assign bus.if_valid    = if_valid_q;
   assign bus.fetch_count = cnt_q;
endmodule
